// File: rtl/rnn_accel_if.sv
// rnn_accel_if
//   Simple memory-mapped bus used by the host to program and read the RNN
//   cell accelerator.
//   Signals:
//     read     - read strobe (host -> accel)
//     write    - write strobe (host -> accel)
//     addr     - word address, low byte decoded (host -> accel)
//     data_in  - write data (host -> accel)
//     data_out - registered read data (accel -> host)
//   Modports: master (host side), slave (accelerator side).
interface rnn_accel_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output read, output write, output addr, output data_in,
                  input data_out);
  modport slave  (input read, input write, input addr, input data_in,
                  output data_out);
endinterface

// File: rtl/rnn_accel.sv
// rnn_accel
//   Single-layer Elman RNN cell: h' = hardtanh(x*W + h*U), one MAC per cycle.
//   The host loads x, W, U (and optionally h) over the bus, then starts a step.
//   h stays resident between steps so sequences can be processed.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous reset, active HIGH despite its name
//     bus   - rnn_accel_if slave (read/write/addr/data_in/data_out)
//   Register map (addr[7:0]): 0 CTRL, 1 X, 2 W, 3 U, 4..4+HID_DIM-1 H.

// Vector storage with a guarded indexed write port; out-of-range writes drop.
module rnn_vec_store #(
  parameter int N  = 2,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [15:0]          idx,
  input  logic signed [DW-1:0] value,
  output logic signed [DW-1:0] vector_out [N]
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic signed [DW-1:0] vector [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) vector[i] <= '0;
    end else if (we && (32'(idx) < N)) begin
      vector[idx[IW-1:0]] <= value;
    end
  end

  assign vector_out = vector;
endmodule

// Matrix storage with a guarded {row, col} write port; no wrap-around.
module rnn_mat_store #(
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [7:0]           row,
  input  logic [7:0]           col,
  input  logic signed [DW-1:0] value,
  output logic signed [DW-1:0] matrix_out [ROWS][COLS]
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic signed [DW-1:0] matrix [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) matrix[r][c] <= '0;
    end else if (we && (32'(row) < ROWS) && (32'(col) < COLS)) begin
      matrix[row[RW-1:0]][col[CW-1:0]] <= value;
    end
  end

  assign matrix_out = matrix;
endmodule

module rnn_accel #(
  parameter int IN_DIM  = 2,
  parameter int HID_DIM = 4,
  parameter int DW      = 16,
  parameter int FRAC    = 8
) (
  input logic        clk,
  input logic        rst_n,
  rnn_accel_if.slave bus
);
  localparam int STEPS = IN_DIM + HID_DIM;
  localparam int TW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int JW    = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int XW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int PW    = 2 * DW;
  localparam int ACCW  = 2 * DW + 8;
  localparam logic signed [ACCW-1:0] CLAMP_HI = ACCW'(1 <<< FRAC);
  localparam logic signed [ACCW-1:0] CLAMP_LO = -CLAMP_HI;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0]   x_vec  [IN_DIM];
  logic signed [DW-1:0]   w_mat  [IN_DIM][HID_DIM];
  logic signed [DW-1:0]   u_mat  [HID_DIM][HID_DIM];
  logic signed [DW-1:0]   h      [HID_DIM];
  logic signed [DW-1:0]   h_next [HID_DIM];
  logic signed [ACCW-1:0] acc, acc_sum, shifted;
  logic signed [DW-1:0]   op_a, op_b, col_result;
  logic signed [PW-1:0]   prod;
  logic [TW-1:0]          t;
  logic [JW-1:0]          j, h_sel, hk;
  logic [XW-1:0]          xi;
  logic [7:0]             reg_addr;
  logic [31:0]            rd_mux;
  logic busy, done, last_mac, last_col;
  logic h_addr_hit, start_req, clear_req, host_wr, x_we, w_we, u_we, h_we;
  logic addr_unused;

  assign reg_addr    = bus.addr[7:0];
  assign addr_unused = ^bus.addr[31:8];
  assign busy        = (state == S_RUN);
  assign h_addr_hit  = (reg_addr >= 8'd4) && (reg_addr < 8'(4 + HID_DIM));
  assign h_sel       = JW'(reg_addr - 8'd4);

  // Host writes to storage are locked out while a step is running so the
  // MAC sequence always sees a stable x/W/U/h snapshot.
  assign host_wr   = bus.write && !busy;
  assign start_req = host_wr && (reg_addr == 8'd0) && bus.data_in[0];
  assign clear_req = host_wr && (reg_addr == 8'd0) && bus.data_in[1];
  assign x_we      = host_wr && (reg_addr == 8'd1);
  assign w_we      = host_wr && (reg_addr == 8'd2);
  assign u_we      = host_wr && (reg_addr == 8'd3);
  assign h_we      = host_wr && h_addr_hit;

  rnn_vec_store #(.N(IN_DIM), .DW(DW)) input_char (
    .clk(clk), .rst(rst_n), .we(x_we), .idx(bus.data_in[31:16]),
    .value(bus.data_in[DW-1:0]), .vector_out(x_vec));

  rnn_mat_store #(.ROWS(IN_DIM), .COLS(HID_DIM), .DW(DW)) rnn_0 (
    .clk(clk), .rst(rst_n), .we(w_we), .row(bus.data_in[31:24]),
    .col(bus.data_in[23:16]), .value(bus.data_in[DW-1:0]), .matrix_out(w_mat));

  rnn_mat_store #(.ROWS(HID_DIM), .COLS(HID_DIM), .DW(DW)) rnn_1 (
    .clk(clk), .rst(rst_n), .we(u_we), .row(bus.data_in[31:24]),
    .col(bus.data_in[23:16]), .value(bus.data_in[DW-1:0]), .matrix_out(u_mat));

  assign last_mac = (t == TW'(STEPS - 1));
  assign last_col = (j == JW'(HID_DIM - 1));

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: idle until a start, run until the last MAC of the last column.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_RUN;
      S_RUN:   if (last_mac && last_col) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // MAC operand selection: the first IN_DIM steps of a column walk x/W,
  // the remaining HID_DIM steps walk the old h against U.
  always_comb begin
    xi   = XW'(t);
    hk   = JW'(t - TW'(IN_DIM));
    op_a = '0;
    op_b = '0;
    if (t < TW'(IN_DIM)) begin
      op_a = x_vec[xi];
      op_b = w_mat[xi][j];
    end else begin
      op_a = h[hk];
      op_b = u_mat[hk][j];
    end
    prod    = PW'(op_a) * PW'(op_b);
    acc_sum = acc + ACCW'(prod);
    shifted = acc_sum >>> FRAC;
    if (shifted > CLAMP_HI)      col_result = CLAMP_HI[DW-1:0];
    else if (shifted < CLAMP_LO) col_result = CLAMP_LO[DW-1:0];
    else                         col_result = shifted[DW-1:0];
  end

  // Datapath: accumulator/counters, shadow h_next, resident h and done flag.
  // The final column's result goes straight into h alongside the shadow copy
  // so the whole vector updates on a single edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc  <= '0;
      t    <= '0;
      j    <= '0;
      done <= 1'b0;
      for (int k = 0; k < HID_DIM; k++) begin
        h[k]      <= '0;
        h_next[k] <= '0;
      end
    end else begin
      if (start_req) begin
        acc  <= '0;
        t    <= '0;
        j    <= '0;
        done <= 1'b0;
      end
      if (clear_req) begin
        for (int k = 0; k < HID_DIM; k++) h[k] <= '0;
      end else if (h_we) begin
        h[h_sel] <= bus.data_in[DW-1:0];
      end
      if (busy) begin
        if (last_mac) begin
          acc       <= '0;
          t         <= '0;
          h_next[j] <= col_result;
          j         <= last_col ? '0 : j + 1'b1;
          if (last_col) begin
            for (int k = 0; k < HID_DIM; k++)
              h[k] <= (JW'(k) == j) ? col_result : h_next[k];
            done <= 1'b1;
          end
        end else begin
          acc <= acc_sum;
          t   <= t + 1'b1;
        end
      end
    end
  end

  // Read mux; unmapped and write-only addresses read as zero.
  always_comb begin
    rd_mux = '0;
    if (reg_addr == 8'd0)      rd_mux = {30'b0, busy, done};
    else if (reg_addr == 8'd1) rd_mux = 32'({x_vec[1], x_vec[0]});
    else if (h_addr_hit)       rd_mux = 32'(h[h_sel]);
  end

  // Registered read data; samples pre-write state when read and write coincide.
  always_ff @(posedge clk) begin
    if (rst_n)         bus.data_out <= '0;
    else if (bus.read) bus.data_out <= rd_mux;
  end
endmodule

// File: tb/tb_rnn_accel.sv
// tb_rnn_accel
//   Self-checking bench for rnn_accel. Drives the bus through the interface,
//   keeps a plain-arithmetic model of x, W, U and h, and compares bus reads
//   and hierarchical storage probes against it.
module tb_rnn_accel;
  logic clk = 1'b0;
  logic rst_n;
  int   n_compared = 0;
  int   n_mismatched = 0;

  int x_m [2];
  int w_m [2][4];
  int u_m [4][4];
  int h_m [4];

  rnn_accel_if bus ();

  rnn_accel #(.IN_DIM(2), .HID_DIM(4), .DW(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int s16(input logic [31:0] v);
    logic signed [15:0] tmp;
    tmp = v[15:0];
    return int'(tmp);
  endfunction

  function automatic logic [31:0] sx16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive, let the edge commit, release strobes 1ns later.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    bus.read    = rd;
    bus.write   = wr;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic model_reset();
    foreach (x_m[i]) x_m[i] = 0;
    foreach (w_m[r, c]) w_m[r][c] = 0;
    foreach (u_m[r, c]) u_m[r][c] = 0;
    foreach (h_m[i]) h_m[i] = 0;
  endtask

  // Model of an idle-time host write.
  task automatic model_apply(input logic [31:0] a, input logic [31:0] d);
    int idx, r, c;
    idx = int'(d[31:16]);
    r   = int'(d[31:24]);
    c   = int'(d[23:16]);
    case (a)
      0: if (d[1]) foreach (h_m[i]) h_m[i] = 0;
      1: if (idx < 2) x_m[idx] = s16(d);
      2: if (r < 2 && c < 4) w_m[r][c] = s16(d);
      3: if (r < 4 && c < 4) u_m[r][c] = s16(d);
      4, 5, 6, 7: h_m[a - 4] = s16(d);
      default: ;
    endcase
  endtask

  // h' = hardtanh((x*W + h*U) >>> 8), all columns from the old h.
  task automatic model_step();
    int hn [4];
    for (int jj = 0; jj < 4; jj++) begin
      longint acc;
      longint res;
      acc = 0;
      for (int i = 0; i < 2; i++) acc += longint'(x_m[i]) * longint'(w_m[i][jj]);
      for (int k = 0; k < 4; k++) acc += longint'(h_m[k]) * longint'(u_m[k][jj]);
      res = acc >>> 8;
      if (res > 256) res = 256;
      if (res < -256) res = -256;
      hn[jj] = int'(res);
    end
    h_m = hn;
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, a, d);
    model_apply(a, d);
  endtask

  task automatic host_read(input logic [31:0] a, output logic [31:0] v);
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    v = bus.data_out;
  endtask

  task automatic check_h_reads(input string tag);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      host_read(32'(4 + k), v);
      checkOutput($sformatf("%s h%0d", tag, k), v, h_m[k]);
    end
  endtask

  task automatic check_storage(input string tag);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("%s x%0d", tag, i), sx16(dut.input_char.vector[i]), x_m[i]);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        checkOutput($sformatf("%s w%0d%0d", tag, r, c), sx16(dut.rnn_0.matrix[r][c]), w_m[r][c]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        checkOutput($sformatf("%s u%0d%0d", tag, r, c), sx16(dut.rnn_1.matrix[r][c]), u_m[r][c]);
  endtask

  // Start a step and poll CTRL every cycle. Status is read through the
  // registered port, so read k returns the status right after edge k-1:
  // busy on reads 1..24, done on read 25. On cycle 3 a start+clear is written
  // alongside the read (must be ignored while busy); with poke set, cycle 5
  // instead writes H0 (also ignored while busy).
  task automatic run_step(input bit poke, input string tag);
    logic [31:0] v;
    int done_at, busy_reads;
    done_at    = 0;
    busy_reads = 0;
    applyStimulus(1'b0, 1'b1, 32'd0, 32'h1);
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 5) begin
        applyStimulus(1'b0, 1'b1, 32'd4, 32'h0000_1234);
      end else begin
        applyStimulus(1'b1, (k == 3), 32'd0, 32'h3);
        v = bus.data_out;
        if (v == 32'h2) busy_reads++;
        if (v == 32'h1) begin
          done_at = k;
          break;
        end
      end
    end
    checkOutput({tag, " done_cycle"}, done_at, 25);
    checkOutput({tag, " busy_reads"}, busy_reads, poke ? 23 : 24);
    model_step();
    host_read(32'd0, v);
    checkOutput({tag, " done_hold"}, v, 32'h1);
    check_h_reads(tag);
  endtask

  initial begin
    logic [31:0] v;
    int wv [8];
    int hq [4];

    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;

    // Reset held for five edges.
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    host_read(32'd0, v);
    checkOutput("reset ctrl", v, 32'h0);
    check_h_reads("reset");
    check_storage("reset");

    // X load, each entry checked one cycle after its write.
    host_write(32'd1, 32'h0000_0002);
    checkOutput("x_load0", sx16(dut.input_char.vector[0]), 32'd2);
    host_write(32'd1, 32'h0001_FFFD);
    checkOutput("x_load1", sx16(dut.input_char.vector[1]), 32'hFFFF_FFFD);
    host_read(32'd1, v);
    checkOutput("x_read", v, 32'hFFFD_0002);

    // W load back-to-back, then an out-of-range row.
    wv = '{2, -10, -10, 3, 6, 9, 12, 1};
    for (int i = 0; i < 8; i++) begin
      int r, c, val;
      r = i / 4; c = i % 4; val = wv[i];
      host_write(32'd2, {r[7:0], c[7:0], val[15:0]});
      checkOutput($sformatf("w_load%0d%0d", r, c), sx16(dut.rnn_0.matrix[r][c]), val);
    end
    host_write(32'd2, {8'd2, 8'd0, 16'd5});
    check_storage("w_oor");

    // U load with r+c.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int val;
        val = r + c;
        host_write(32'd3, {r[7:0], c[7:0], val[15:0]});
        checkOutput($sformatf("u_load%0d%0d", r, c), sx16(dut.rnn_1.matrix[r][c]), val);
      end

    // Other out-of-range / unmapped accesses.
    host_write(32'd1, 32'h0002_7777);
    host_write(32'd3, {8'd4, 8'd0, 16'd9});
    host_write(32'd8, 32'h0000_5555);
    host_read(32'd8, v);
    checkOutput("unmapped read", v, 32'h0);
    host_read(32'd2, v);
    checkOutput("w read zero", v, 32'h0);
    check_storage("oor");

    // Q8.8 step: x=[256,0], W row0=[128,-128,512,0], U=0, h=0.
    host_write(32'd1, 32'h0000_0100);
    host_write(32'd1, 32'h0001_0000);
    wv = '{128, -128, 512, 0, 0, 0, 0, 0};
    for (int c = 0; c < 4; c++) begin
      int val;
      val = wv[c];
      host_write(32'd2, {8'd0, c[7:0], val[15:0]});
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) host_write(32'd3, {r[7:0], c[7:0], 16'd0});
    host_write(32'd0, 32'h2);
    run_step(1'b0, "step1");
    hq = '{128, -128, 256, 0};
    for (int k = 0; k < 4; k++) checkOutput($sformatf("step1 const h%0d", k), 32'(h_m[k]), hq[k]);

    // Recurrence: U=256*I, x=0, W=0, h=[64,-64,300,0].
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) host_write(32'd3, {r[7:0], c[7:0], (r == c) ? 16'd256 : 16'd0});
    host_write(32'd1, 32'h0000_0000);
    host_write(32'd1, 32'h0001_0000);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) host_write(32'd2, {r[7:0], c[7:0], 16'd0});
    host_write(32'd4, 32'h0000_0040);
    host_write(32'd5, 32'h0000_FFC0);
    host_write(32'd6, 32'h0000_012C);
    host_write(32'd7, 32'h0000_0000);
    run_step(1'b1, "recur");
    hq = '{64, -64, 256, 0};
    for (int k = 0; k < 4; k++) checkOutput($sformatf("recur const h%0d", k), 32'(h_m[k]), hq[k]);

    // Read and write on the same edge returns the pre-write value.
    host_write(32'd4, 32'h0000_0AAA);
    applyStimulus(1'b1, 1'b1, 32'd4, 32'h0000_0BBB);
    checkOutput("rw same cycle", bus.data_out, 32'h0000_0AAA);
    model_apply(32'd4, 32'h0000_0BBB);
    host_read(32'd4, v);
    checkOutput("rw after", v, 32'h0000_0BBB);

    // Randomized steps against the model.
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 2; i++) begin
        int val;
        val = int'($urandom_range(0, 1023)) - 512;
        host_write(32'd1, {i[15:0], val[15:0]});
      end
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 4; c++) begin
          int val;
          val = int'($urandom_range(0, 1023)) - 512;
          host_write(32'd2, {r[7:0], c[7:0], val[15:0]});
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          int val;
          val = int'($urandom_range(0, 511)) - 256;
          host_write(32'd3, {r[7:0], c[7:0], val[15:0]});
        end
      if (round == 0) begin
        for (int k = 0; k < 4; k++) begin
          int val;
          val = int'($urandom_range(0, 511)) - 256;
          host_write(32'(4 + k), {16'h0, val[15:0]});
        end
      end
      run_step(round[0], $sformatf("rand%0d", round));
    end

    // Reset in the middle of a step aborts it and clears everything.
    applyStimulus(1'b0, 1'b1, 32'd0, 32'h1);
    repeat (10) applyStimulus(1'b0, 1'b0, 32'd0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    host_read(32'd0, v);
    checkOutput("midreset ctrl", v, 32'h0);
    check_h_reads("midreset");
    check_storage("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
